gpzda_emitter: RTL and testbench



---
 rtl/gpzda_emitter.sv | 150 +++++++++++++++
 tb/tb_gpzda_emitter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpzda_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpzda_emitter                                                |
// | Description : Serialises one NMEA ZDA sentence from snapshotted packed-BCD |
// |               time/date/zone fields, one byte per valid/ready handshake,   |
// |               and appends the XOR checksum as two hex digits.              |
// |               Optional macro GPZDA_EMITTER_CRLF_EN appends CR/LF (38 bytes |
// |               instead of 36).                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpzda_emitter #(
   parameter logic [15:0] TALKER    = "GP",
   parameter int          HEX_LOWER = 0
) (
   input  logic        clock,
   input  logic        restart_n,
   input  logic        start,
   input  logic [31:0] time_bcd,
   input  logic [31:0] date_bcd,
   input  logic [15:0] zone_bcd,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_SEND = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

`ifdef GPZDA_EMITTER_CRLF_EN
   localparam logic [5:0] c_LAST_IDX = 6'd37;
`else
   localparam logic [5:0] c_LAST_IDX = 6'd35;
`endif

   logic [1:0]  r_state;
   logic [5:0]  r_idx;
   logic [7:0]  r_csum;
   logic [31:0] r_time;
   logic [31:0] r_date;
   logic [15:0] r_zone;
   logic [7:0]  w_byte;
   logic        w_xfer;

   // BCD nibble to ASCII; 10-15 deliberately map onto ':'..'?' unchecked
   function automatic logic [7:0] f_dig(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   // Checksum nibble to ASCII hex, case selected by HEX_LOWER
   function automatic logic [7:0] f_hex(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (HEX_LOWER != 0)
         return 8'h57 + {4'h0, n};
      else
         return 8'h37 + {4'h0, n};
   endfunction

   // Byte map: select the character for the current sentence position
   always_comb begin
      w_byte = 8'h00;
      case (r_idx)
         6'd0  : w_byte = 8'h24;
         6'd1  : w_byte = TALKER[15:8];
         6'd2  : w_byte = TALKER[7:0];
         6'd3  : w_byte = 8'h5A;
         6'd4  : w_byte = 8'h44;
         6'd5  : w_byte = 8'h41;
         6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd30 : w_byte = 8'h2C;
         6'd7  : w_byte = f_dig(r_time[31:28]);
         6'd8  : w_byte = f_dig(r_time[27:24]);
         6'd9  : w_byte = f_dig(r_time[23:20]);
         6'd10 : w_byte = f_dig(r_time[19:16]);
         6'd11 : w_byte = f_dig(r_time[15:12]);
         6'd12 : w_byte = f_dig(r_time[11:8]);
         6'd13 : w_byte = 8'h2E;
         6'd14 : w_byte = f_dig(r_time[7:4]);
         6'd15 : w_byte = f_dig(r_time[3:0]);
         6'd17 : w_byte = f_dig(r_date[31:28]);
         6'd18 : w_byte = f_dig(r_date[27:24]);
         6'd20 : w_byte = f_dig(r_date[23:20]);
         6'd21 : w_byte = f_dig(r_date[19:16]);
         6'd23 : w_byte = f_dig(r_date[15:12]);
         6'd24 : w_byte = f_dig(r_date[11:8]);
         6'd25 : w_byte = f_dig(r_date[7:4]);
         6'd26 : w_byte = f_dig(r_date[3:0]);
         6'd28 : w_byte = f_dig(r_zone[15:12]);
         6'd29 : w_byte = f_dig(r_zone[11:8]);
         6'd31 : w_byte = f_dig(r_zone[7:4]);
         6'd32 : w_byte = f_dig(r_zone[3:0]);
         6'd33 : w_byte = 8'h2A;
         6'd34 : w_byte = f_hex(r_csum[7:4]);
         6'd35 : w_byte = f_hex(r_csum[3:0]);
`ifdef GPZDA_EMITTER_CRLF_EN
         6'd36 : w_byte = 8'h0D;
         6'd37 : w_byte = 8'h0A;
`endif
         default : w_byte = 8'h00;
      endcase
   end

   assign w_xfer    = (r_state == c_SEND) && out_ready;
   assign out_valid = (r_state == c_SEND);
   assign busy      = (r_state != c_IDLE);
   assign done      = (r_state == c_DONE);
   assign out_data  = out_valid ? w_byte : 8'h00;

   // Sentence FSM: snapshot on start, walk the byte map, fold checksum on transfers
   always_ff @(posedge clock or negedge restart_n) begin
      if (!restart_n) begin
         r_state <= c_IDLE;
         r_idx   <= 6'd0;
         r_csum  <= 8'h00;
         r_time  <= 32'h0;
         r_date  <= 32'h0;
         r_zone  <= 16'h0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_time  <= time_bcd;
                  r_date  <= date_bcd;
                  r_zone  <= zone_bcd;
                  r_idx   <= 6'd0;
                  r_csum  <= 8'h00;
                  r_state <= c_SEND;
               end
            end
            c_SEND: begin
               if (w_xfer) begin
                  // checksum covers everything between '$' and '*'
                  if ((r_idx >= 6'd1) && (r_idx <= 6'd32))
                     r_csum <= r_csum ^ w_byte;
                  if (r_idx == c_LAST_IDX)
                     r_state <= c_DONE;
                  else
                     r_idx <= r_idx + 6'd1;
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpzda_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gpzda_emitter                                             |
// | Description : Self-checking bench for gpzda_emitter. Two instances (GP,    |
// |               uppercase hex / GN, lowercase hex) share stimulus; a         |
// |               sentence-level model predicts every output cycle.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_gpzda_emitter;

`ifdef GPZDA_EMITTER_CRLF_EN
   localparam int c_LEN = 38;
`else
   localparam int c_LEN = 36;
`endif

   logic        clock     = 1'b0;
   logic        restart_n = 1'b0;
   logic        start     = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] time_bcd  = 32'h0;
   logic [31:0] date_bcd  = 32'h0;
   logic [15:0] zone_bcd  = 16'h0;
   logic [7:0]  data_a, data_b;
   logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

   int errors = 0;
   int checks = 0;

   bit   rand_ready = 1'b0;
   int   ph = 0;             // 0 idle, 1 sending, 2 done pulse
   int   done_cnt = 0;
   bit   prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] qa[$], qb[$], bld[$], cap_a[$], cap_b[$];

   gpzda_emitter #(.TALKER("GP"), .HEX_LOWER(0)) u_dut_a (
      .clock(clock), .restart_n(restart_n), .start(start),
      .time_bcd(time_bcd), .date_bcd(date_bcd), .zone_bcd(zone_bcd),
      .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
      .busy(busy_a), .done(done_a));

   gpzda_emitter #(.TALKER("GN"), .HEX_LOWER(1)) u_dut_b (
      .clock(clock), .restart_n(restart_n), .start(start),
      .time_bcd(time_bcd), .date_bcd(date_bcd), .zone_bcd(zone_bcd),
      .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
      .busy(busy_b), .done(done_b));

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- sentence model ----------------
   function automatic void put_dig(input logic [31:0] v, input int n);
      for (int k = n - 1; k >= 0; k--)
         bld.push_back(8'h30 + {4'h0, v[4*k +: 4]});
   endfunction

   function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return lower ? 8'h57 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic void build(input logic [15:0] tk, input bit lower,
                                 input logic [31:0] t, input logic [31:0] d,
                                 input logic [15:0] z);
      logic [7:0] cs;
      bld.delete();
      bld.push_back(8'h24);
      bld.push_back(tk[15:8]);
      bld.push_back(tk[7:0]);
      bld.push_back(8'h5A); bld.push_back(8'h44); bld.push_back(8'h41);
      bld.push_back(8'h2C); put_dig({8'h0, t[31:8]}, 6);
      bld.push_back(8'h2E); put_dig({24'h0, t[7:0]}, 2);
      bld.push_back(8'h2C); put_dig({24'h0, d[31:24]}, 2);
      bld.push_back(8'h2C); put_dig({24'h0, d[23:16]}, 2);
      bld.push_back(8'h2C); put_dig({16'h0, d[15:0]}, 4);
      bld.push_back(8'h2C); put_dig({24'h0, z[15:8]}, 2);
      bld.push_back(8'h2C); put_dig({24'h0, z[7:0]}, 2);
      cs = 8'h00;
      for (int i = 1; i < bld.size(); i++) cs ^= bld[i];
      bld.push_back(8'h2A);
      bld.push_back(hexc(cs[7:4], lower));
      bld.push_back(hexc(cs[3:0], lower));
`ifdef GPZDA_EMITTER_CRLF_EN
      bld.push_back(8'h0D);
      bld.push_back(8'h0A);
`endif
   endfunction

   // Compare DUT against the model each cycle, then advance the model to the next edge
   always @(negedge clock) begin
      if (!restart_n) begin
         chk("rst_outs_a", {valid_a, busy_a, done_a, data_a}, 32'h0);
         chk("rst_outs_b", {valid_b, busy_b, done_b, data_b}, 32'h0);
         ph = 0; qa.delete(); qb.delete(); prev_hold = 1'b0;
      end else begin
         chk("valid", {valid_a, valid_b}, {2{ph == 1}});
         chk("busy",  {busy_a, busy_b},   {2{ph != 0}});
         chk("done",  {done_a, done_b},   {2{ph == 2}});
         if (ph == 1) begin
            chk("byte_a", data_a, qa[0]);
            chk("byte_b", data_b, qb[0]);
         end
         if (prev_hold && valid_a) chk("stall_hold", data_a, prev_data);
         if (done_a) done_cnt++;
         if (valid_a && out_ready) begin
            cap_a.push_back(data_a);
            cap_b.push_back(data_b);
         end
         prev_hold = valid_a && !out_ready;
         prev_data = data_a;
         case (ph)
            0: if (start) begin
                  build("GP", 1'b0, time_bcd, date_bcd, zone_bcd); qa = bld;
                  build("GN", 1'b1, time_bcd, date_bcd, zone_bcd); qb = bld;
                  ph = 1;
               end
            1: if (out_ready) begin
                  void'(qa.pop_front());
                  void'(qb.pop_front());
                  if (qa.size() == 0) ph = 2;
               end
            default: ph = 0;
         endcase
      end
   end

   // Ready driver: always-ready or pseudo-random stalls
   initial forever begin
      @(posedge clock); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick;
      @(posedge clock); #1;
   endtask

   task automatic pulse_start(input bit expect_accept);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (expect_accept) begin
         chk("lat_valid", valid_a, 1'b1);
         chk("lat_dollar", data_a, 8'h24);
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_a && n < budget) begin tick(); n++; end
      if (!done_a) begin
         errors++;
         $display("FAIL wait_done: timeout after %0d cycles", budget);
      end
   endtask

   task automatic wait_bytes(input int k, input int budget);
      int n = 0;
      while (cap_a.size() < k && n < budget) begin tick(); n++; end
      if (cap_a.size() < k) begin
         errors++;
         $display("FAIL wait_bytes: got %0d bytes expected %0d", cap_a.size(), k);
      end
   endtask

   task automatic chk_str(input string nm, input string s);
      chk({nm, "_len"}, cap_a.size(), s.len());
      for (int i = 0; i < s.len() && i < cap_a.size(); i++) chk(nm, cap_a[i], s[i]);
   endtask

   task automatic chk_model(input string nm);
      build("GP", 1'b0, time_bcd, date_bcd, zone_bcd);
      chk({nm, "_len_a"}, cap_a.size(), bld.size());
      for (int i = 0; i < bld.size() && i < cap_a.size(); i++) chk({nm, "_a"}, cap_a[i], bld[i]);
      build("GN", 1'b1, time_bcd, date_bcd, zone_bcd);
      chk({nm, "_len_b"}, cap_b.size(), bld.size());
      for (int i = 0; i < bld.size() && i < cap_b.size(); i++) chk({nm, "_b"}, cap_b[i], bld[i]);
   endtask

   task automatic clear_caps;
      cap_a.delete();
      cap_b.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      string exp_s;
      int    d0;
      exp_s = "$GPZDA,201530.00,04,07,2002,00,00*60";
`ifdef GPZDA_EMITTER_CRLF_EN
      exp_s = {exp_s, "\r\n"};
`endif

      // reset, then idle with start low
      repeat (3) tick();
      restart_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outs", {valid_a, busy_a, done_a, data_a}, 32'h0);
      end

      // fixed sentence, sink always ready
      time_bcd = 32'h20153000; date_bcd = 32'h04072002; zone_bcd = 16'h0000;
      clear_caps(); d0 = done_cnt;
      pulse_start(1'b1);
      wait_done(200);
      repeat (3) tick();
      chk_str("fixed", exp_s);
      chk("fixed_len", cap_a.size(), c_LEN);
      chk("fixed_done_cnt", done_cnt - d0, 1);

      // same sentence with random stalls; start during DONE cycle is dropped
      rand_ready = 1'b1;
      clear_caps(); d0 = done_cnt;
      pulse_start(1'b1);
      wait_done(600);
      pulse_start(1'b0);
      repeat (3) tick();
      chk("done_start_dropped", busy_a, 1'b0);
      chk_str("stalled", exp_s);
      chk("stalled_done_cnt", done_cnt - d0, 1);
      rand_ready = 1'b0;
      tick();

      // snapshot isolation and start-while-busy
      clear_caps(); d0 = done_cnt;
      pulse_start(1'b1);
      wait_bytes(10, 200);
      time_bcd = 32'h99999999;
      wait_bytes(20, 200);
      pulse_start(1'b0);
      wait_done(200);
      repeat (5) tick();
      chk_str("snapshot", exp_s);
      chk("snapshot_done_cnt", done_cnt - d0, 1);
      chk("snapshot_idle", valid_a, 1'b0);

      // asynchronous abort mid-sentence
      time_bcd = 32'h20153000;
      clear_caps(); d0 = done_cnt;
      pulse_start(1'b1);
      wait_bytes(15, 200);
      restart_n = 1'b0;
      #1;
      chk("abort_valid", {valid_a, valid_b}, 2'b00);
      chk("abort_busy", {busy_a, busy_b}, 2'b00);
      repeat (3) tick();
      restart_n = 1'b1;
      repeat (2) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      clear_caps();
      pulse_start(1'b1);
      wait_done(200);
      repeat (2) tick();
      chk_str("after_abort", exp_s);

      // GN / lowercase instance: nibble A at h1, zone digit B
      time_bcd = 32'hA0153000; zone_bcd = 16'h000B;
      clear_caps();
      pulse_start(1'b1);
      wait_done(200);
      repeat (2) tick();
      chk("gn_len", cap_b.size(), c_LEN);
      chk("gn_talker", {cap_b[1], cap_b[2]}, 16'h474E);
      chk("gn_h1", cap_b[7], 8'h3A);
      chk("gn_csum", {cap_b[33], cap_b[34], cap_b[35]}, 24'h2A3764);
      chk("gp_csum", {cap_a[34], cap_a[35]}, 16'h3633);
      chk_model("gn_model");

      // randomized sentences with random stalls
      rand_ready = 1'b1;
      for (int r = 0; r < 6; r++) begin
         time_bcd = $urandom; date_bcd = $urandom; zone_bcd = 16'($urandom);
         clear_caps(); d0 = done_cnt;
         pulse_start(1'b0);
         wait_done(600);
         repeat (2) tick();
         chk_model("rand");
         chk("rand_done_cnt", done_cnt - d0, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
